irq_arbiter: RTL
================

IRQ_ARBITER -- requirements
Module: irq_arbiter

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'hF0: base of the 3-byte register window.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 255: the number of REQ-state cycles allowed before the grant is withdrawn.
REQ-003 SHALL have the following ports, with clock and reset first:
- CLK  input  1  system clock, 50 MHz.
- RESETN  input  1  reset, asynchronous, active-low.
- SRC_IRQ  input  4  peripheral interrupt levels; each level is held high until that source is acked.
- SRC_ACK  output  4  one-hot acknowledge pulse, one cycle wide, to the granted source.
- CPU_IRQ  output  1  interrupt request to the processor.
- CPU_IRQ_ID  output  2  index of the granted source; valid while CPU_IRQ=1.
- CPU_ACK  input  1  processor acknowledge, single-cycle pulse.
- BUS_DATA  inout  8  shared data bus.
- BUS_ADDR  input  8  bus address.
- BUS_WE  input  1  bus write enable.

Function
REQ-004 SHALL define req = SRC_IRQ & mask[3:0], where mask is a 4-bit register.
REQ-005 SHALL implement the FSM states IDLE, REQ, ACK and GAP.
REQ-006 IDLE: if req!=0, the FSM SHALL select winner per REQ-013, register CPU_IRQ_ID=winner and CPU_IRQ=1, and go to REQ on the next edge; otherwise it SHALL stay in IDLE.
REQ-007 REQ: CPU_IRQ SHALL stay high and ID SHALL stay stable; a cycle counter SHALL increment each cycle, starting from 0 on REQ entry.
REQ-008 REQ with CPU_ACK=1: the FSM SHALL go to ACK, and CPU_IRQ SHALL drop on the same edge.
REQ-009 ACK: SRC_ACK[ID] SHALL be 1 for exactly one cycle, after which the FSM SHALL go to GAP.
REQ-010 GAP: the FSM SHALL spend one cycle with no arbitration (lets the source deassert), then return to IDLE.
- Ack-to-next-CPU_IRQ latency SHALL be at least 3 cycles.
REQ-011 In REQ, if the counter reaches ACK_TIMEOUT without CPU_ACK, CPU_IRQ SHALL drop and the FSM SHALL go to GAP with no SRC_ACK.
- The source keeps pending and is re-arbitrated.
REQ-012 In REQ, if req[ID] falls to 0 (mask write or source drop), the grant SHALL be withdrawn immediately in the same way as REQ-011.
- CPU_ACK arriving in the same cycle as a withdrawal SHALL win.
- CPU_ACK arriving in the same cycle as a timeout SHALL win.
REQ-013 Arbitration SHALL be fixed priority, with index 0 highest, unless modified by the Configuration section.
REQ-014 A CPU_ACK in IDLE, ACK or GAP SHALL be ignored.
REQ-015 The register window SHALL be:
- BASE+0: mask, RW, bits [3:0]; bits [7:4] read 0.
- BASE+1: {4'b0, req}, RO.
- BASE+2: {CPU_IRQ, 4'b0, timeout_flag, CPU_IRQ_ID}, RO.
REQ-016 A write with BUS_WE=1 and BUS_ADDR=BASE+0 SHALL update mask on that edge; writes to the other addresses SHALL be ignored.
REQ-017 A read with BUS_WE=0 and BUS_ADDR in the window SHALL register the data and a drive-enable on the edge.
- BUS_DATA SHALL be driven the following cycle.
- BUS_DATA SHALL be high-Z otherwise.
REQ-018 timeout_flag SHALL set on a REQ-011 timeout and clear when BASE+2 is read.
- If a set and a clear occur in the same cycle, the set SHALL win.

Reset
REQ-019 While RESETN=0, the outputs and state SHALL be:
- state=IDLE.
- CPU_IRQ=0, CPU_IRQ_ID=0, SRC_ACK=0.
- mask=4'hF, counter=0, timeout_flag=0, rr_ptr=3.
- bus drive-enable=0, so BUS_DATA is Z.
REQ-020 Reset asserted mid-handshake SHALL abort without any SRC_ACK pulse; after release, pending sources SHALL be re-arbitrated from IDLE.

Configuration
REQ-021 With IRQ_RR_EN defined, arbitration SHALL be round-robin:
- The search starts at rr_ptr+1 (mod 4).
- rr_ptr SHALL update to ID only when an ACK state is entered.
REQ-022 Without IRQ_RR_EN, arbitration SHALL be fixed priority per REQ-013, and rr_ptr SHALL be absent.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- SRC_IRQ=0001, CPU_ACK 5 cycles after CPU_IRQ -> ID=0, then SRC_ACK=0001 for 1 cycle, then CPU_IRQ low for ≥2 cycles.
- SRC_IRQ=0110 held, two acks -> fixed: ID=1, ID=1 again if held (source not dropping); IRQ_RR_EN: ID=1, then ID=2.
- SRC_IRQ=1000, no CPU_ACK -> CPU_IRQ drops after 255 REQ cycles, no SRC_ACK, BASE+2 reads bit2=1, then re-grant ID=3.
- In REQ with ID=2, write 8'h0B to BASE+0 -> CPU_IRQ drops next cycle, no SRC_ACK; read BASE+1 -> 8'h00 if only src2 pending.
- Read BASE+0 after reset -> BUS_DATA=8'h0F one cycle later, Z otherwise; RESETN pulse during ACK -> SRC_ACK=0, CPU_IRQ=0.

Source files
------------

// File: rtl/irq_arbiter.sv
// irq_arbiter: four-source interrupt arbiter with a CPU request/ack handshake, an ack timeout, and a 3-byte bus register window.
// Define IRQ_RR_EN for round-robin arbitration. The default build uses fixed priority, with source 0 highest.
module irq_arbiter #(
  parameter logic [7:0] BASE_ADDR   = 8'hF0,
  parameter int         ACK_TIMEOUT = 255
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic [3:0] SRC_IRQ,
  output logic [3:0] SRC_ACK,
  output logic       CPU_IRQ,
  output logic [1:0] CPU_IRQ_ID,
  input  logic       CPU_ACK,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE
);

  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, ACK, GAP} state_t;

  state_t        state_q, state_d;
  logic          irq_q, irq_d;
  logic [1:0]    irqId_q, irqId_d;
  logic [3:0]    srcAck_q, srcAck_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    mask_q, mask_d;
  logic          timeoutFlag_q, timeoutFlag_d;
  logic          busOe_q, busOe_d;
  logic [7:0]    rdata_q, rdata_d;

  logic [3:0] req;
  logic [1:0] winner;
  logic       timeoutSet;
  logic       enterAck;
  logic [7:0] offset;
  logic       inWin;
  logic       unusedBusHi;

  assign req    = SRC_IRQ & mask_q;
  assign offset = BUS_ADDR - BASE_ADDR;
  assign inWin  = (offset < 8'd3);

`ifdef IRQ_RR_EN
  logic [1:0] rrPtr_q;
  logic [1:0] idx;

  // Scan from rrPtr+1 upwards (mod 4). Iterating in reverse lets the nearest candidate win.
  always_comb begin
    winner = 2'd0;
    idx    = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = rrPtr_q + 2'(k + 1);
      if (req[idx]) winner = idx;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN)       rrPtr_q <= 2'd3;
    else if (enterAck) rrPtr_q <= irqId_q;
  end
`else
  always_comb begin
    winner = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req[k]) winner = 2'(k);
    end
  end
`endif

  // A CPU ack is checked before a withdrawal or a timeout, so it wins a same-cycle collision.
  always_comb begin
    state_d    = state_q;
    irq_d      = irq_q;
    irqId_d    = irqId_q;
    srcAck_d   = 4'b0000;
    cnt_d      = cnt_q;
    timeoutSet = 1'b0;
    enterAck   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = REQ;
          irq_d   = 1'b1;
          irqId_d = winner;
          cnt_d   = '0;
        end
      end
      REQ: begin
        if (CPU_ACK) begin
          state_d  = ACK;
          irq_d    = 1'b0;
          enterAck = 1'b1;
          srcAck_d = 4'b0001 << irqId_q;
        end else if (!req[irqId_q]) begin
          state_d = GAP;
          irq_d   = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = GAP;
          irq_d      = 1'b0;
          timeoutSet = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ACK: state_d = GAP;
      GAP: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Register file. A read is captured on the clock edge and placed on the bus for the following cycle.
  always_comb begin
    mask_d        = mask_q;
    busOe_d       = 1'b0;
    rdata_d       = rdata_q;
    timeoutFlag_d = timeoutFlag_q;
    if (BUS_WE && offset == 8'd0) mask_d = BUS_DATA[3:0];
    if (!BUS_WE && inWin) begin
      busOe_d = 1'b1;
      case (offset[1:0])
        2'd0:    rdata_d = {4'b0000, mask_q};
        2'd1:    rdata_d = {4'b0000, req};
        default: rdata_d = {irq_q, 4'b0000, timeoutFlag_q, irqId_q};
      endcase
      if (offset[1:0] == 2'd2) timeoutFlag_d = 1'b0;
    end
    if (timeoutSet) timeoutFlag_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q       <= IDLE;
      irq_q         <= 1'b0;
      irqId_q       <= 2'd0;
      srcAck_q      <= 4'b0000;
      cnt_q         <= '0;
      mask_q        <= 4'hF;
      timeoutFlag_q <= 1'b0;
      busOe_q       <= 1'b0;
      rdata_q       <= 8'h00;
    end else begin
      state_q       <= state_d;
      irq_q         <= irq_d;
      irqId_q       <= irqId_d;
      srcAck_q      <= srcAck_d;
      cnt_q         <= cnt_d;
      mask_q        <= mask_d;
      timeoutFlag_q <= timeoutFlag_d;
      busOe_q       <= busOe_d;
      rdata_q       <= rdata_d;
    end
  end

  assign unusedBusHi = ^BUS_DATA[7:4];
  assign BUS_DATA    = busOe_q ? rdata_q : 8'hzz;
  assign CPU_IRQ     = irq_q;
  assign CPU_IRQ_ID  = irqId_q;
  assign SRC_ACK     = srcAck_q;

endmodule
